csoc_rsp_tx: RTL and testbench

- Return path from the CSoC to the host UART.
- Captures bytes the CSoC presents on csoc_data_i with a csoc_uart_write strobe and buffers them in a small FIFO.
- Serialises the FIFO contents into the uart_tx start/ready handshake, so the host sees CSoC output and scan-out data.
- Drives the tx_data / new_tx_data / tx_busy side that cmd_parser leaves open.

---
 rtl/csoc_test_pkg.sv | 27 ++
 rtl/csoc_sync_fifo.sv | 61 ++++++
 rtl/csoc_rsp_tx.sv | 156 +++++++++++++++
 tb/tb_csoc_rsp_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csoc_test_pkg.sv
// Shared definitions for the CSoC response path: FSM encoding, ASCII constants
// and the nibble-to-hex helper used by the optional hex dump mode.
package csoc_test_pkg;

   localparam int RSP_FIFO_AW = 4;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_LOAD      = 3'd1;
   localparam state_t ST_START     = 3'd2;
   localparam state_t ST_WAIT_BUSY = 3'd3;
   localparam state_t ST_WAIT_IDLE = 3'd4;

   localparam logic [7:0] ASC_0  = 8'h30;
   localparam logic [7:0] ASC_A  = 8'h41;
   localparam logic [7:0] ASC_SP = 8'h20;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         hex_ascii = ASC_0 + {4'd0, nib};
      end else begin
         hex_ascii = ASC_A + {4'd0, nib} - 8'd10;
      end
   endfunction

endpackage

// File: rtl/csoc_sync_fifo.sv
// Synchronous show-ahead FIFO; a push while full is silently dropped, with
// fullness judged before any pop in the same cycle.
module csoc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [WIDTH-1:0] mem [0:(1<<AW)-1];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (level == DEPTH);
   assign empty = (level == {(AW+1){1'b0}});
   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;
   assign rdata = mem[rd_ptr];

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at 2**AW
   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         level  <= {(AW+1){1'b0}};
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/csoc_rsp_tx.sv
// CSoC -> host UART return path: strobe synchroniser, byte FIFO and uart_tx
// handshake FSM. Define CSOC_RSP_HEX_EN to send each byte as "HH " ASCII hex.
module csoc_rsp_tx
   import csoc_test_pkg::*;
#(
   parameter int FIFO_AW  = RSP_FIFO_AW,
   parameter int BUSY_TMO = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               csoc_uart_write,
   input  logic [7:0]         csoc_data_i,
   input  logic               clr,
   output logic [7:0]         tx_data,
   output logic               tx_start,
   input  logic               tx_ready,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   output logic               busy
);

   localparam int TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

   logic          sync1, sync2, prev;
   logic          push, pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_rdata;
   logic [7:0]    char_buf;
   logic [7:0]    next_char;
   logic          last_char;
   logic [TW-1:0] tmo_cnt;
   state_t        state;

   // Strobe synchroniser plus edge-detect history
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= csoc_uart_write;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   // The FIFO entry itself is the capture register for csoc_data_i
   assign push = sync2 & ~prev & ~clr;
   assign pop  = (state == ST_IDLE) & ~fifo_empty;

   csoc_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (clr),
      .push  (push),
      .wdata (csoc_data_i),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Sticky drop flag
   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         overflow <= 1'b0;
      end else if (push && fifo_full) begin
         overflow <= 1'b1;
      end else begin
         overflow <= overflow;
      end
   end

`ifdef CSOC_RSP_HEX_EN
   logic [1:0] char_idx;

   always_comb begin
      next_char = ASC_SP;
      case (char_idx)
         2'd0:    next_char = hex_ascii(char_buf[7:4]);
         2'd1:    next_char = hex_ascii(char_buf[3:0]);
         default: next_char = ASC_SP;
      endcase
   end

   assign last_char = (char_idx == 2'd2);

   // Character index within the current byte
   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         char_idx <= 2'd0;
      end else if (state == ST_WAIT_IDLE && tx_ready) begin
         char_idx <= last_char ? 2'd0 : char_idx + 2'd1;
      end else begin
         char_idx <= char_idx;
      end
   end
`else
   assign next_char = char_buf;
   assign last_char = 1'b1;
`endif

   // Transmit FSM; tx_data only changes in LOAD
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         tx_data  <= 8'h00;
         tx_start <= 1'b0;
         char_buf <= 8'h00;
         tmo_cnt  <= {TW{1'b0}};
      end else if (clr) begin
         state    <= ST_IDLE;
         tx_start <= 1'b0;
         tmo_cnt  <= {TW{1'b0}};
      end else begin
         tx_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  char_buf <= fifo_rdata;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               tx_data <= next_char;
               state   <= ST_START;
            end
            ST_START: begin
               if (tx_ready) begin
                  tx_start <= 1'b1;
                  tmo_cnt  <= {TW{1'b0}};
                  state    <= ST_WAIT_BUSY;
               end
            end
            ST_WAIT_BUSY: begin
               // A uart_tx that never drops tx_ready is treated as having taken the char
               if (!tx_ready || tmo_cnt == TMO_LAST) begin
                  state <= ST_WAIT_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            ST_WAIT_IDLE: begin
               if (tx_ready) begin
                  state <= last_char ? ST_IDLE : ST_LOAD;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (fifo_level != {(FIFO_AW+1){1'b0}}) | (state != ST_IDLE);

endmodule

// File: tb/tb_csoc_rsp_tx.sv
// Directed bench for csoc_rsp_tx: vector table of single bytes plus overflow,
// slow tx_ready, clr and mid-character reset sequences.
module tb_csoc_rsp_tx;

   localparam int AW  = 2;
   localparam int TMO = 4;
`ifdef CSOC_RSP_HEX_EN
   localparam int CPB = 3;
`else
   localparam int CPB = 1;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] c0;
      logic [7:0] c1;
      logic [7:0] c2;
   } vec_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          csoc_uart_write = 1'b0;
   logic [7:0]    csoc_data_i = 8'h00;
   logic          clr = 1'b0;
   logic          tx_ready = 1'b1;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic [AW:0]   fifo_level;
   logic          overflow;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int mode = 0;      // 0: uart model, 1: tx_ready held low, 2: tx_ready held high
   int hold_cnt = 0;
   int rise_cyc = 0;
   int t0 = 0;
   int k = 0;
   int n_before = 0;
   logic [7:0] cap_q[$];
   int         start_q[$];
   vec_t       vecs [6];

   csoc_rsp_tx #(.FIFO_AW(AW), .BUSY_TMO(TMO)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .csoc_uart_write (csoc_uart_write),
      .csoc_data_i     (csoc_data_i),
      .clr             (clr),
      .tx_data         (tx_data),
      .tx_start        (tx_start),
      .tx_ready        (tx_ready),
      .fifo_level      (fifo_level),
      .overflow        (overflow),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_char(input logic [7:0] b, input int idx);
`ifdef CSOC_RSP_HEX_EN
      logic [3:0] n;
      if (idx == 2) return 8'h20;
      n = (idx == 0) ? b[7:4] : b[3:0];
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
`else
      return (idx == 0) ? b : 8'h00;
`endif
   endfunction

   // uart_tx stand-in: records each start and drops tx_ready for 3 clocks
   always @(negedge clk) begin
      if (tx_start) begin
         cap_q.push_back(tx_data);
         start_q.push_back(cyc);
         chk("start_while_ready", {31'd0, tx_ready}, 32'd1);
      end
      case (mode)
         1: tx_ready = 1'b0;
         2: tx_ready = 1'b1;
         default: begin
            if (tx_start) begin
               tx_ready = 1'b0;
               hold_cnt = 3;
            end else if (hold_cnt > 0) begin
               hold_cnt--;
               if (hold_cnt == 0) tx_ready = 1'b1;
            end else begin
               tx_ready = 1'b1;
            end
         end
      endcase
   end

   task automatic put_byte(input logic [7:0] b);
      csoc_data_i = b;
      repeat (3) @(posedge clk);
      #1;
      csoc_uart_write = 1'b1;
      rise_cyc = cyc;
      repeat (4) @(posedge clk);
      #1;
      csoc_uart_write = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef CSOC_RSP_HEX_EN
      vecs[0] = '{8'hA5, 8'h41, 8'h35, 8'h20};
      vecs[1] = '{8'h00, 8'h30, 8'h30, 8'h20};
      vecs[2] = '{8'hFF, 8'h46, 8'h46, 8'h20};
      vecs[3] = '{8'h09, 8'h30, 8'h39, 8'h20};
      vecs[4] = '{8'h0A, 8'h30, 8'h41, 8'h20};
      vecs[5] = '{8'h3C, 8'h33, 8'h43, 8'h20};
`else
      vecs[0] = '{8'hA5, 8'hA5, 8'h00, 8'h00};
      vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
      vecs[3] = '{8'h09, 8'h09, 8'h00, 8'h00};
      vecs[4] = '{8'h0A, 8'h0A, 8'h00, 8'h00};
      vecs[5] = '{8'h3C, 8'h3C, 8'h00, 8'h00};
`endif

      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_level", {29'd0, fifo_level}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single bytes through an idle uart
      for (int i = 0; i < 6; i++) begin
         cap_q.delete();
         start_q.delete();
         put_byte(vecs[i].data);
         wait_idle("vec_idle", 200);
         chk("vec_nchar", cap_q.size(), CPB);
         for (int j = 0; j < CPB; j++) begin
            logic [7:0] e;
            e = (j == 0) ? vecs[i].c0 : (j == 1) ? vecs[i].c1 : vecs[i].c2;
            if (j < cap_q.size()) chk("vec_char", {24'd0, cap_q[j]}, {24'd0, e});
         end
         if (start_q.size() > 0) chk("vec_latency", start_q[0] - rise_cyc, 32'd6);
      end

      // Overflow: one byte sits in the char buffer, four fill the FIFO, the sixth is lost
      cap_q.delete();
      start_q.delete();
      mode = 1;
      for (int i = 1; i <= 6; i++) put_byte(8'(i));
      chk("ovf_level", {29'd0, fifo_level}, 32'd4);
      chk("ovf_flag", {31'd0, overflow}, 32'd1);
      chk("ovf_no_start", start_q.size(), 32'd0);
      mode = 0;
      wait_idle("ovf_drain", 600);
      chk("ovf_nchar", cap_q.size(), 5 * CPB);
      for (int i = 0; i < 5 * CPB; i++) begin
         if (i < cap_q.size()) chk("ovf_char", {24'd0, cap_q[i]}, {24'd0, exp_char(8'(i / CPB + 1), i % CPB)});
      end
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);

      // tx_ready never falls: timeout after TMO clocks in WAIT_BUSY
      cap_q.delete();
      start_q.delete();
      mode = 2;
      put_byte(8'h5A);
      chk("slow_start", start_q.size(), 32'd1);
      t0 = (start_q.size() > 0) ? start_q[0] : cyc;
      wait_cyc(t0 + TMO);
      chk("slow_busy_hold", {31'd0, busy}, 32'd1);
      wait_cyc(t0 + TMO + 1);
`ifdef CSOC_RSP_HEX_EN
      chk("slow_busy_next", {31'd0, busy}, 32'd1);
`else
      chk("slow_busy_next", {31'd0, busy}, 32'd0);
`endif
      wait_cyc(t0 + TMO + 2);
      chk("slow_one_start", start_q.size(), 32'd1);
`ifdef CSOC_RSP_HEX_EN
      wait_cyc(t0 + TMO + 4);
      if (start_q.size() > 1) chk("slow_second_start", start_q[1], t0 + TMO + 3);
`endif
      mode = 0;
      wait_idle("slow_idle", 300);
      chk("slow_nchar", cap_q.size(), CPB);

      // clr while the second character is in flight
      cap_q.delete();
      start_q.delete();
      mode = 1;
      for (int i = 0; i < 6; i++) put_byte(8'h40 + 8'(i));
      chk("clr_pre_ovf", {31'd0, overflow}, 32'd1);
      mode = 0;
      k = 0;
      while (start_q.size() < 2 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("clr_second_start", {31'd0, start_q.size() >= 2}, 32'd1);
      chk("clr_pre_level", {31'd0, fifo_level != 3'd0}, 32'd1);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk("clr_level", {29'd0, fifo_level}, 32'd0);
      chk("clr_overflow", {31'd0, overflow}, 32'd0);
      chk("clr_tx_start", {31'd0, tx_start}, 32'd0);
      chk("clr_idle", {31'd0, busy}, 32'd0);
      n_before = start_q.size();
      repeat (30) @(posedge clk);
      #1;
      chk("clr_no_start", start_q.size(), n_before);

      // Reset for one clock while in WAIT_BUSY
      cap_q.delete();
      start_q.delete();
      mode = 1;
      put_byte(8'h11);
      put_byte(8'h22);
      chk("rst_pre_level", {29'd0, fifo_level}, 32'd1);
      mode = 2;
      k = 0;
      while (start_q.size() < 1 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("rst_pre_start", start_q.size(), 32'd1);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      chk("mid_rst_tx_data", {24'd0, tx_data}, 32'h00);
      chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("mid_rst_level", {29'd0, fifo_level}, 32'd0);
      chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      mode = 0;
      repeat (5) @(posedge clk);
      #1;
      cap_q.delete();
      start_q.delete();
      put_byte(8'h7E);
      wait_idle("post_rst_idle", 200);
      chk("post_rst_nchar", cap_q.size(), CPB);
      for (int j = 0; j < CPB; j++) begin
         if (j < cap_q.size()) chk("post_rst_char", {24'd0, cap_q[j]}, {24'd0, exp_char(8'h7E, j)});
      end
      if (start_q.size() > 0) chk("post_rst_latency", start_q[0] - rise_cyc, 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
